// File: rtl/fifo_byte_reader_pkg.sv
// Shared types and constants for the FIFO read-side byte drain engine.
// Provides the byte-count helper, serializer state encoding and marker default.
package fifo_byte_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } ser_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/fifo_byte_reader_word_serializer.sv
// Serializes one DATA_WIDTH word into bytes, MSB first, on a valid/ready stream.
// Ports: clk, rst (sync, active-high); load_valid/load_data in, load_ready out
// (word can be taken this cycle); m_data, m_valid, m_last out, m_ready in.
// Build option FIFO_READER_SYNC_EN: prefix every word with one SYNC_BYTE beat.
module word_serializer
    import fifo_byte_reader_pkg::*;
#(
    parameter int         DATA_WIDTH = 24,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int IW    = $clog2(BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    ser_state_t            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IW-1:0]         idx;
    logic                  releasing;
    logic                  do_load;

    // The last data byte leaves this cycle, so a new word may land
    // in the same edge and keep m_valid high without a bubble.
    assign releasing  = (state == ST_DATA) && m_ready && (idx == LAST_IDX);
    assign load_ready = (state == ST_IDLE) || releasing;
    assign do_load    = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            idx     <= '0;
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (do_load) begin
            idx     <= '0;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
`ifdef FIFO_READER_SYNC_EN
            state   <= ST_SYNC;
            shreg   <= load_data;
            m_data  <= SYNC_BYTE;
`else
            // shreg keeps only the bytes not yet presented
            state   <= ST_DATA;
            shreg   <= load_data << 8;
            m_data  <= load_data[DATA_WIDTH-1 -: 8];
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    m_valid <= 1'b0;
                end
                ST_SYNC: begin
                    if (m_ready) begin
                        state  <= ST_DATA;
                        m_data <= shreg[DATA_WIDTH-1 -: 8];
                        shreg  <= shreg << 8;
                        m_last <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (m_ready) begin
                        if (idx == LAST_IDX) begin
                            state   <= ST_IDLE;
                            m_valid <= 1'b0;
                            m_data  <= 8'h00;
                            m_last  <= 1'b0;
                        end else begin
                            idx    <= idx + IW'(1);
                            m_data <= shreg[DATA_WIDTH-1 -: 8];
                            shreg  <= shreg << 8;
                            m_last <= ((idx + IW'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_byte_reader.sv
// Read-side drain engine: pops FIFO words and streams them as bytes, MSB first.
// Ports: clk, rst (sync, active-high); fifo_rd_en out, fifo_rd_data and
// fifo_rd_empty in; m_data, m_valid, m_last out, m_ready in.
// Build option FIFO_READER_SYNC_EN: each word is preceded by a SYNC_BYTE beat.
module fifo_byte_reader
    import fifo_byte_reader_pkg::*;
#(
    parameter int         DATA_WIDTH = 24,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16) begin : g_bad_width
        $error("fifo_byte_reader: DATA_WIDTH must be a multiple of 8, >= 16");
    end

    logic                  inflight;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;

    // One read outstanding at most, and only when there is a place
    // (shift or hold) guaranteed to take the returning word.
    assign fifo_rd_en = !rst && !fifo_rd_empty && !inflight && !hold_valid;

    // hold and inflight are mutually exclusive: a pop needs hold empty,
    // and hold is only ever filled from the inflight word.
    assign load_valid = hold_valid || inflight;
    assign load_data  = hold_valid ? hold_data : fifo_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (hold_valid && load_ready) begin
                hold_valid <= 1'b0;
            end else if (inflight && !load_ready) begin
                hold_data  <= fifo_rd_data;
                hold_valid <= 1'b1;
            end
        end
    end

    word_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_BYTE  (SYNC_BYTE)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Scoreboard bench for fifo_byte_reader with a behavioural FIFO read port.
// Honours FIFO_READER_SYNC_EN by expecting an A5 beat ahead of each word.
module tb_fifo_byte_reader;

    localparam int DW    = 24;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;

    logic [DW-1:0] fifo_q[$];
    logic [8:0]    exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            pops     = 0;
    int            cyc      = 0;

    fifo_byte_reader #(.DATA_WIDTH(DW), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
`ifdef FIFO_READER_SYNC_EN
        exp_q.push_back({1'b0, 8'hA5});
`endif
        for (int i = BYTES - 1; i >= 0; i--)
            exp_q.push_back({(i == 0), w[i*8 +: 8]});
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // FIFO read port: data one cycle after pop, registered empty flag
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) begin
            check("pop_not_empty", 32'(fifo_rd_empty), 32'd0);
            pops++;
            if (fifo_q.size() > 0)
                fifo_rd_data <= fifo_q.pop_front();
        end
        fifo_rd_empty <= (fifo_q.size() == 0);
    end

    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && stall_prev) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
            check("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(m_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("byte_data", 32'(m_data), 32'(e[7:0]));
                check("byte_last", 32'(m_last), 32'(e[8]));
            end
        end
        stall_prev = !rst && m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int t;
        int k;
        int gaps;
        int seen_en;
        int seen_v;

        repeat (3) tick();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        rst = 1'b0;
        tick();

        // single word, latency and pop count
        m_ready = 1'b1;
        p0 = pops;
        push_word(24'h123456);
        k = 0;
        while (!fifo_rd_en && k < 20) begin
            tick();
            k++;
        end
        check("pop_seen", 32'(fifo_rd_en), 32'd1);
        t = cyc;
        k = 0;
        while (!m_valid && k < 20) begin
            tick();
            k++;
        end
        check("first_latency", 32'(cyc - t), 32'd2);
        wait_drain(50);
        check("single_pops", 32'(pops - p0), 32'd1);

        // backpressure on byte 34
        p0 = pops;
        push_word(24'h123456);
        push_word(24'hABCDEF);
        push_word(24'h13579B);
        k = 0;
        while (!(m_valid && m_data == 8'h34) && k < 30) begin
            tick();
            k++;
        end
        check("bp_reach_34", 32'(m_data), 32'h34);
        m_ready = 1'b0;
        repeat (5) tick();
        check("bp_pops", 32'(pops - p0), 32'd2);
        m_ready = 1'b1;
        wait_drain(100);
        check("bp_total_pops", 32'(pops - p0), 32'd3);

        // gap-free burst of four words
        p0 = pops;
        push_word(24'h010203);
        push_word(24'h040506);
        push_word(24'h070809);
        push_word(24'h0A0B0C);
        k = 0;
        while (!m_valid && k < 20) begin
            tick();
            k++;
        end
        gaps = 0;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            if (!m_valid) gaps++;
            tick();
            k++;
        end
        check("burst_drain", 32'(exp_q.size()), 32'd0);
        check("burst_gaps", 32'(gaps), 32'd0);
        check("burst_pops", 32'(pops - p0), 32'd4);

        // idle with empty FIFO, then pop on the flag's fall
        seen_en = 0;
        seen_v  = 0;
        repeat (20) begin
            tick();
            if (fifo_rd_en) seen_en++;
            if (m_valid) seen_v++;
        end
        check("idle_rd_en", 32'(seen_en), 32'd0);
        check("idle_valid", 32'(seen_v), 32'd0);
        push_word(24'hFEDCBA);
        tick();
        check("empty_fall", 32'(fifo_rd_empty), 32'd0);
        check("pop_same_cycle", 32'(fifo_rd_en), 32'd1);
        wait_drain(50);

        // reset with a word in flight and one half sent
        p0 = pops;
        push_word(24'hAABBCC);
        push_word(24'hDDEEFF);
        k = 0;
        while ((pops - p0) < 2 && k < 30) begin
            tick();
            k++;
        end
        check("rst_two_pops", 32'(pops - p0), 32'd2);
        rst = 1'b1;
        m_ready = 1'b0;
        tick();
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        check("mid_rst_last", 32'(m_last), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        check("no_rewind", 32'(fifo_q.size()), 32'd0);
        repeat (3) tick();
        check("post_rst_idle", 32'(m_valid), 32'd0);
        push_word(24'h5A6B7C);
        wait_drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
